// File: rtl/fp_issue_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// fp_issue_pipe_reg_if
// Bundle of signals between the FP issue stage and the FP register-read stage,
// passing through the fp_issue_pipe_reg pipeline register.
//
// Signals:
//   in_valid      [LANES]            per-lane valid from issue stage
//   in_payload    [LANES*PAYLOAD_W]  per-lane payload, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   stall                            hold every stage
//   flush                            invalidate every stage and the incoming ops
//   kill_lane     [LANES]            invalidate lane i everywhere
//   out_valid     [LANES]            last-stage per-lane valid
//   out_payload   [LANES*PAYLOAD_W]  last-stage payload
//   occupancy     [OCC_W]            valid entries across all stages
//   delivered_cnt [CNT_W]            saturating count of lane-ops delivered
//
// Modports:
//   master - the issue-side driver (drives inputs, observes outputs)
//   slave  - the pipeline register itself
// ----------------------------------------------------------------------------
interface fp_issue_pipe_reg_if #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 1,
    parameter int CNT_W     = 16
);
    localparam int OCC_W = $clog2(LANES * DEPTH + 1);

    logic [LANES-1:0]           in_valid;
    logic [LANES*PAYLOAD_W-1:0] in_payload;
    logic                       stall;
    logic                       flush;
    logic [LANES-1:0]           kill_lane;
    logic [LANES-1:0]           out_valid;
    logic [LANES*PAYLOAD_W-1:0] out_payload;
    logic [OCC_W-1:0]           occupancy;
    logic [CNT_W-1:0]           delivered_cnt;

    modport master (
        output in_valid, in_payload, stall, flush, kill_lane,
        input  out_valid, out_payload, occupancy, delivered_cnt
    );

    modport slave (
        input  in_valid, in_payload, stall, flush, kill_lane,
        output out_valid, out_payload, occupancy, delivered_cnt
    );
endinterface

// File: rtl/fp_issue_pipe_reg.sv
// ----------------------------------------------------------------------------
// fp_issue_pipe_reg
// Multi-lane, DEPTH-stage pipeline register between FP issue and FP
// register-read. Supports global stall, global flush (highest priority) and
// per-lane kill, reports the number of valid entries held, and keeps a
// saturating count of lane-ops that left the last stage.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - fp_issue_pipe_reg_if.slave (inputs, stall/flush/kill, outputs,
//          occupancy, delivered_cnt)
// ----------------------------------------------------------------------------
module fp_issue_pipe_reg #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_issue_pipe_reg_if.slave   bus
);
    localparam int PW      = LANES * PAYLOAD_W;
    localparam int CELLS   = LANES * DEPTH;
    localparam int OCC_W   = $clog2(CELLS + 1);
    localparam int DELTA_W = $clog2(LANES + 1);
    localparam int SUM_W   = CNT_W + DELTA_W;

    // Flattened view of every cell: cell (s, i) sits at index s*LANES + i.
    logic [CELLS-1:0]           vld_all;
    logic [CELLS*PAYLOAD_W-1:0] pay_all;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic                 src_vld;
            logic [PAYLOAD_W-1:0] src_pay;
            logic                 vld_d, vld_q;
            logic [PAYLOAD_W-1:0] pay_d, pay_q;

            if (s == 0) begin : g_src_in
                assign src_vld = bus.in_valid[i];
                assign src_pay = bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end else begin : g_src_prev
                assign src_vld = vld_all[(s-1)*LANES + i];
                assign src_pay = pay_all[((s-1)*LANES + i)*PAYLOAD_W +: PAYLOAD_W];
            end

            // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
            always_comb begin
                vld_d = vld_q & ~bus.kill_lane[i];
                pay_d = pay_q;
                if (bus.flush) begin
                    vld_d = 1'b0;
                end else if (!bus.stall) begin
                    vld_d = src_vld & ~bus.kill_lane[i];
                    pay_d = src_pay;
                end
            end

            // NOTE: payload storage is reset too, because out_payload must read 0 while rst is high.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    pay_q <= '0;
                end else begin
                    // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
                    vld_q <= vld_d;
                    pay_q <= pay_d;
                end
            end

            assign vld_all[s*LANES + i] = vld_q;
            assign pay_all[(s*LANES + i)*PAYLOAD_W +: PAYLOAD_W] = pay_q;
        end
    end

    assign bus.out_valid   = vld_all[(DEPTH-1)*LANES +: LANES];
    assign bus.out_payload = pay_all[(DEPTH-1)*PW +: PW];

    // Occupancy: popcount over every registered valid bit.
    logic [OCC_W-1:0] occ;
    always_comb begin
        occ = '0;
        for (int k = 0; k < CELLS; k++) begin
            occ = occ + OCC_W'(vld_all[k]);
        end
    end
    assign bus.occupancy = occ;

    // Delivered-op counter. A lane killed on the same edge it would leave
    // is dropped, not delivered.
    logic [LANES-1:0]   leaving;
    logic [DELTA_W-1:0] delta;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    assign leaving = bus.out_valid & ~bus.kill_lane;

    always_comb begin
        delta = '0;
        for (int i = 0; i < LANES; i++) begin
            delta = delta + DELTA_W'(leaving[i]);
        end
        sum   = SUM_W'(cnt_q) + SUM_W'(delta);
        cnt_d = cnt_q;
        if (!bus.flush && !bus.stall) begin
            // Wider sum lets the overflow be seen, so the count clamps instead of wrapping.
            if (sum > SUM_W'({CNT_W{1'b1}})) begin
                cnt_d = {CNT_W{1'b1}};
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.delivered_cnt = cnt_q;
endmodule

// File: tb/tb_fp_issue_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_fp_issue_pipe_reg
// Scoreboard bench for fp_issue_pipe_reg (LANES=2, PAYLOAD_W=16, DEPTH=3,
// CNT_W=4). The driver applies directed then random stimulus and, at each
// edge, advances a reference model that tracks in-flight ops by lane and age;
// the expected outputs are queued and a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_fp_issue_pipe_reg;
    localparam int LANES     = 2;
    localparam int PAYLOAD_W = 16;
    localparam int DEPTH     = 3;
    localparam int CNT_W     = 4;
    localparam int PW        = LANES * PAYLOAD_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_issue_pipe_reg_if #(
        .LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) bus ();

    fp_issue_pipe_reg #(
        .LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: a bag of in-flight ops, each with its lane and how
    // many stages it has passed (age DEPTH-1 means it sits at the output).
    typedef struct {
        int                   lane;
        logic [PAYLOAD_W-1:0] pay;
        int                   age;
    } op_t;

    typedef struct {
        logic [LANES-1:0] ov;
        logic [PW-1:0]    op;
        int               occ;
        int               cnt;
        bit               in_rst;
    } exp_t;

    op_t  inflight[$];
    int   m_cnt;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [LANES-1:0] v, input logic [PW-1:0] p,
                              input bit st, input bit fl, input logic [LANES-1:0] k);
        op_t nxt[$];
        if (r) begin
            inflight.delete();
            m_cnt = 0;
        end else if (fl) begin
            inflight.delete();
        end else if (st) begin
            foreach (inflight[j]) if (!k[inflight[j].lane]) nxt.push_back(inflight[j]);
            inflight = nxt;
        end else begin
            foreach (inflight[j]) begin
                op_t o;
                o = inflight[j];
                if (k[o.lane]) continue;
                if (o.age == DEPTH - 1) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    o.age++;
                    nxt.push_back(o);
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (v[i] && !k[i]) begin
                    op_t o;
                    o.lane = i;
                    o.pay  = p[i*PAYLOAD_W +: PAYLOAD_W];
                    o.age  = 0;
                    nxt.push_back(o);
                end
            end
            inflight = nxt;
        end
    endtask

    function automatic exp_t snapshot(input bit r);
        exp_t e;
        e.ov = '0; e.op = '0; e.occ = 0; e.cnt = 0; e.in_rst = r;
        if (!r) begin
            e.occ = inflight.size();
            e.cnt = m_cnt;
            foreach (inflight[j]) begin
                if (inflight[j].age == DEPTH - 1) begin
                    e.ov[inflight[j].lane] = 1'b1;
                    e.op[inflight[j].lane*PAYLOAD_W +: PAYLOAD_W] = inflight[j].pay;
                end
            end
        end
        return e;
    endfunction

    // One clock of stimulus. mid_rst raises rst a couple of ns after the edge,
    // so the monitor sees the asynchronous clear before the next edge.
    task automatic cycle(input logic [LANES-1:0] v, input logic [PW-1:0] p,
                         input bit st, input bit fl, input logic [LANES-1:0] k, input bit mid_rst);
        bus.in_valid   = v;
        bus.in_payload = p;
        bus.stall      = st;
        bus.flush      = fl;
        bus.kill_lane  = k;
        @(posedge clk);
        model_step(rst, v, p, st, fl, k);
        if (mid_rst) model_step(1'b1, v, p, st, fl, k);
        sb.push_back(snapshot(rst || mid_rst));
        #1;
        rst = 1'b0;
        if (mid_rst) begin
            #1;
            rst = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle('0, PW'($urandom), 1'b0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [PW-1:0] pk(input logic [PAYLOAD_W-1:0] l1, input logic [PAYLOAD_W-1:0] l0);
        return {l1, l0};
    endfunction

    // Monitor: the DUT presents outputs every cycle; compare against the
    // oldest expectation.
    always @(negedge clk) begin
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_valid", 64'(bus.out_valid), 64'(e.ov));
            check("occupancy", 64'(bus.occupancy), 64'(e.occ));
            check("delivered_cnt", 64'(bus.delivered_cnt), 64'(e.cnt));
            if (e.in_rst) begin
                check("out_payload_rst", 64'(bus.out_payload), 64'd0);
            end
            for (int i = 0; i < LANES; i++) begin
                if (e.ov[i]) begin
                    check($sformatf("out_payload_l%0d", i),
                          64'(bus.out_payload[i*PAYLOAD_W +: PAYLOAD_W]),
                          64'(e.op[i*PAYLOAD_W +: PAYLOAD_W]));
                end
            end
        end
    end

    initial begin
        bus.in_valid   = '0;
        bus.in_payload = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.kill_lane  = '0;
        m_cnt          = 0;

        // Reset held across the first edge, then released.
        idle(2);

        // Latency: one op pair, visible on the third edge, gone after the fourth.
        cycle(2'b11, pk(16'hB, 16'hA), 1'b0, 1'b0, 2'b00, 1'b0);
        idle(5);

        // Stall hold while payload 1 is at the output.
        cycle(2'b01, pk(16'h0, 16'h1), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, pk(16'h0, 16'h2), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, pk(16'h0, 16'h3), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
        cycle(2'b00, '0, 1'b1, 1'b0, 2'b00, 1'b0);
        idle(4);

        // Flush beats stall, and the input op is discarded.
        cycle(2'b01, pk(16'h0, 16'h11), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, pk(16'h0, 16'h12), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, pk(16'h0, 16'h13), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, pk(16'h0, 16'h14), 1'b1, 1'b1, 2'b00, 1'b0);
        idle(4);

        // Per-lane kill under stall, then under advance.
        cycle(2'b11, pk(16'h21, 16'h20), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b11, pk(16'h23, 16'h22), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b11, pk(16'h25, 16'h24), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b00, '0, 1'b1, 1'b0, 2'b10, 1'b0);
        cycle(2'b11, pk(16'h27, 16'h26), 1'b0, 1'b0, 2'b01, 1'b0);
        idle(4);

        // Counter saturation: two ops per cycle for long enough to clamp.
        for (int j = 0; j < 14; j++) cycle(2'b11, PW'($urandom), 1'b0, 1'b0, 2'b00, 1'b0);
        idle(3);

        // Asynchronous reset mid-cycle with entries in flight.
        cycle(2'b11, PW'($urandom), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b11, PW'($urandom), 1'b0, 1'b0, 2'b00, 1'b0);
        cycle(2'b11, PW'($urandom), 1'b0, 1'b0, 2'b00, 1'b1);
        idle(4);

        // Random traffic.
        for (int j = 0; j < 3000; j++) begin
            logic [LANES-1:0] v, k;
            for (int i = 0; i < LANES; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                k[i] = ($urandom_range(0, 9) == 0);
            end
            cycle(v, PW'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  k, ($urandom_range(0, 199) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_issue_pipe_reg.md
Name: fp_issue_pipe_reg

Overview:
- Parametrised multi-lane pipeline register between the FP issue stage and the FP register-read stage.
- Generalises the fixed single-stage issue→register-read path in three ways:
  - configurable lane count, payload width and stage depth;
  - adds global stall, global flush and per-lane kill;
  - adds a saturating count of ops delivered.
- Instantiated only when the FP pipe is enabled.

Parameters:
- LANES, 2, number of FP issue lanes (≥1)
- PAYLOAD_W, 64, bits of register-read-stage payload per lane (≥1)
- DEPTH, 1, number of register stages from input to output (≥1)
- CNT_W, 16, width of the delivered-op counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  LANES  per-lane valid from issue stage
- in_payload  in  LANES*PAYLOAD_W  per-lane payload; lane i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
- stall  in  1  hold all stages
- flush  in  1  invalidate every stage and the incoming ops
- kill_lane  in  LANES  invalidate lane i in every stage and at the input
- out_valid  out  LANES  per-lane valid to register-read stage (last stage)
- out_payload  out  LANES*PAYLOAD_W  last-stage payload
- occupancy  out  $clog2(LANES*DEPTH+1)  number of valid entries across all stages
- delivered_cnt  out  CNT_W  saturating count of valid lane-ops that left the last stage

Behaviour:
- Clock and reset: one clock, clk; reset is rst, asynchronous and active-high.
- Storage: a LANES×DEPTH array of {valid, payload}. Stage 0 is fed by the inputs; stage DEPTH-1 drives out_*.
- Reset (asynchronous, active-high) clears, independent of clk:
  - all valid bits;
  - all payloads to 0;
  - delivered_cnt to 0.
  - Consequently out_valid=0, out_payload=0 and occupancy=0 while rst is high.
- Per-edge update, in priority order:
  1. flush=1: every valid bit ← 0. Payloads may load or hold (don't-care). Inputs are discarded. Overrides stall and kill_lane.
  2. Else if stall=1:
     - payloads hold;
     - valid[s][i] ← valid[s][i] & ~kill_lane[i];
     - inputs are not captured.
  3. Else (advance):
     - stage0 valid[i] ← in_valid[i] & ~kill_lane[i]; stage0 payload ← in_payload lane i;
     - stage s valid[i] ← valid[s-1][i] & ~kill_lane[i] for s≥1; stage s payload ← stage s-1 payload.
- Latency: an op presented with stall=0 appears on out_* exactly DEPTH cycles later, provided there is no stall, flush or kill in between. Each stall cycle adds one cycle.
- Lane independence: lanes never exchange payload; lane i in → lane i out.
- Payload of an invalid entry is don't-care downstream, but it still shifts (no clock gating required).
- Outputs come straight from registers; no combinational path from any input to out_valid or out_payload.
- occupancy: combinational popcount of all current valid bits, reflecting the registered state.
- delivered_cnt:
  - on an edge with rst=0, flush=0 and stall=0, adds popcount(out_valid & ~kill_lane) as sampled before the edge;
  - saturates at 2^CNT_W-1 and never wraps;
  - flush or stall cycles add 0.
- Simultaneous events: flush with stall → flush wins. kill_lane with stall → the kill still applies to the held entries.
- Reset mid-operation: all in-flight ops are lost, and the counter returns to 0.
- Structure: generate loops over LANES and DEPTH. The DEPTH=1 case must elaborate with no s-1 index.

Test Plan:
- Latency: LANES=2, DEPTH=3; drive in_valid=2'b11 with payloads 0xA/0xB for one cycle, no stall.
  - out_valid=2'b11 with lane0=0xA, lane1=0xB exactly on the third edge; out_valid=0 before that edge and after the following one.
  - delivered_cnt=2 after the next edge.
- Stall hold: DEPTH=2; stream payloads 1,2,3 on lane0; assert stall for 2 cycles while payload 1 is at the output.
  - out_payload stays 1 with valid high for those 2 cycles; 2 and 3 follow in order with no loss or duplication.
- Flush priority: DEPTH=3, 3 ops in flight; assert stall and flush together with in_valid=1.
  - Next cycle: occupancy=0 and out_valid=0.
  - The input op is not captured; delivered_cnt is unchanged.
- Per-lane kill: DEPTH=2, both lanes full in both stages (occupancy=4); pulse kill_lane=2'b10 for one cycle with stall=1.
  - occupancy=2 after the edge, with lane0 entries intact.
  - Pulse kill_lane=2'b01 with stall=0 and in_valid=2'b11 → after the edge, lane0 valid=0 in all stages.
- Counter saturation: CNT_W=4; deliver 2 ops/cycle for 10 cycles.
  - delivered_cnt goes 2,4,…,14, then holds at 15.
- Async reset: assert rst mid-cycle with 4 entries in flight.
  - out_valid, occupancy and delivered_cnt all read 0 before the next clk edge.
  - After rst is released they stay 0 until new ops propagate.
